// File: rtl/clock_pkg.sv
// Shared packed-BCD time type, field slices, alarm FSM states and BCD helpers.
package clock_pkg;

    typedef logic [19:0] hms_t;

    localparam int unsigned HtMsb = 19;
    localparam int unsigned HtLsb = 18;
    localparam int unsigned HuMsb = 17;
    localparam int unsigned HuLsb = 14;
    localparam int unsigned MtMsb = 13;
    localparam int unsigned MtLsb = 11;
    localparam int unsigned MuMsb = 10;
    localparam int unsigned MuLsb = 7;
    localparam int unsigned StMsb = 6;
    localparam int unsigned StLsb = 4;
    localparam int unsigned SuMsb = 3;
    localparam int unsigned SuLsb = 0;

    typedef enum logic [1:0] {
        StIdle,
        StRing,
        StSnooze
    } alarm_state_e;

    function automatic int bcd_hours(hms_t t);
        return 10 * int'(t[HtMsb:HtLsb]) + int'(t[HuMsb:HuLsb]);
    endfunction

    // 12 AM maps to 00, 12 PM stays 12, other PM hours gain 12.
    function automatic hms_t to_24h(hms_t t, logic pm);
        int   h;
        hms_t r;
        h = bcd_hours(t);
        if (h == 12) begin
            h = pm ? 12 : 0;
        end else if (pm) begin
            h = h + 12;
        end
        r = t;
        r[HtMsb:HtLsb] = 2'(h / 10);
        r[HuMsb:HuLsb] = 4'(h % 10);
        return r;
    endfunction

    function automatic logic bcd_time_valid(hms_t t, logic mode12h);
        logic ok;
        int   h;
        h  = bcd_hours(t);
        ok = (t[HuMsb:HuLsb] <= 4'd9) && (t[MuMsb:MuLsb] <= 4'd9) &&
             (t[SuMsb:SuLsb] <= 4'd9) && (t[MtMsb:MtLsb] <= 3'd5) &&
             (t[StMsb:StLsb] <= 3'd5);
        if (mode12h) begin
            ok = ok && (h >= 1) && (h <= 12);
        end else begin
            ok = ok && (h <= 23);
        end
        return ok;
    endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm slot storage: validated, 24h-normalised writes plus the per-slot match vector.
module alarm_slot_bank
    import clock_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [1:0]            wr_id,
    input  hms_t                  wr_time,
    input  logic                  wr_pm,
    input  logic                  wr_arm,
    input  logic                  mode12h,
    input  logic                  match_en,
    input  hms_t                  cur_time,
    output logic [NUM_ALARMS-1:0] match,
    output logic [NUM_ALARMS-1:0] armed
);

    hms_t                  slot_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] arm_q;
    logic                  wr_ok;
    hms_t                  wr_val;

    always_comb begin
        wr_ok  = wr_en && bcd_time_valid(wr_time, mode12h);
        wr_val = mode12h ? to_24h(wr_time, wr_pm) : wr_time;
    end

    // Ids beyond NUM_ALARMS never decode, so such writes fall away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_q[i] <= '0;
            end
            arm_q <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (wr_id == 2'(i)) begin
                    slot_q[i] <= wr_val;
                    arm_q[i]  <= wr_arm;
                end
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i] = match_en && arm_q[i] && (slot_q[i] == cur_time);
        end
    end

    assign armed = arm_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm scheduler: slot bank, pending latch, fixed-priority pick and ring/snooze FSM.
// Define ALARM_BEEP_EN for a 1 s on / 1 s off buzzer while ringing.
module alarm_controller
    import clock_pkg::*;
#(
    parameter int unsigned NUM_ALARMS  = 4,
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [19:0]           cur_time,
    input  logic                  set_time,
    input  logic                  set_alarm,
    input  logic [1:0]            alarm_id,
    input  logic [19:0]           stime_alarm,
    input  logic                  sam_pm,
    input  logic                  alarm_arm,
    input  logic                  mode12h,
    input  logic                  button1,
    input  logic                  button2,
    output logic                  ringing,
    output logic                  snoozing,
    output logic [1:0]            active_id,
    output logic                  buzzer,
    output logic [NUM_ALARMS-1:0] slot_armed
);

    localparam int unsigned CntW = $clog2(SNOOZE_SECS);

    logic                  set_alarm_q, button1_q, button2_q;
    logic                  wr_edge, snooze_edge, dismiss_edge;
    logic [NUM_ALARMS-1:0] match, pending_q, pending_d, grant;
    logic [1:0]            grant_id;
    alarm_state_e          state_q;
    logic [CntW-1:0]       cnt_q;
    logic                  cnt_sat, ring_done, snooze_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_alarm_q <= 1'b0;
            button1_q   <= 1'b0;
            button2_q   <= 1'b0;
        end else begin
            set_alarm_q <= set_alarm;
            button1_q   <= button1;
            button2_q   <= button2;
        end
    end

    assign wr_edge      = set_alarm & ~set_alarm_q;
    assign snooze_edge  = button1 & ~button1_q;
    assign dismiss_edge = button2 & ~button2_q;

    alarm_slot_bank #(
        .NUM_ALARMS(NUM_ALARMS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_edge),
        .wr_id   (alarm_id),
        .wr_time (stime_alarm),
        .wr_pm   (sam_pm),
        .wr_arm  (alarm_arm),
        .mode12h (mode12h),
        .match_en(tick_1hz & ~set_time),
        .cur_time(cur_time),
        .match   (match),
        .armed   (slot_armed)
    );

    // Lowest pending index wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = 2'(i);
            end
        end
    end

    // The grant is consumed only when IDLE launches a ring; fresh matches always land.
    always_comb begin
        pending_d = pending_q | match;
        if (state_q == StIdle) begin
            pending_d = (pending_q & ~grant) | match;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign cnt_sat     = &cnt_q;
    assign ring_done   = tick_1hz && (cnt_q == CntW'(RING_SECS - 1));
    assign snooze_done = tick_1hz && (cnt_q == CntW'(SNOOZE_SECS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            active_id <= '0;
            ringing   <= 1'b0;
            snoozing  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|pending_q) begin
                        state_q   <= StRing;
                        active_id <= grant_id;
                        cnt_q     <= '0;
                        ringing   <= 1'b1;
                    end
                end
                StRing: begin
                    if (dismiss_edge || ring_done) begin
                        state_q   <= StIdle;
                        active_id <= '0;
                        ringing   <= 1'b0;
                    end else if (snooze_edge) begin
                        state_q  <= StSnooze;
                        cnt_q    <= '0;
                        ringing  <= 1'b0;
                        snoozing <= 1'b1;
                    end else if (tick_1hz && !cnt_sat) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StSnooze: begin
                    if (dismiss_edge) begin
                        state_q   <= StIdle;
                        active_id <= '0;
                        snoozing  <= 1'b0;
                    end else if (snooze_done) begin
                        state_q  <= StRing;
                        cnt_q    <= '0;
                        snoozing <= 1'b0;
                        ringing  <= 1'b1;
                    end else if (tick_1hz && !cnt_sat) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    active_id <= '0;
                    ringing   <= 1'b0;
                    snoozing  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALARM_BEEP_EN
    logic beep_q;

    // Phase sits high outside RING so every ring starts audible, then flips per tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beep_q <= 1'b0;
        end else if (!ringing) begin
            beep_q <= 1'b1;
        end else if (tick_1hz) begin
            beep_q <= ~beep_q;
        end
    end

    assign buzzer = ringing & beep_q;
`else
    assign buzzer = ringing;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Directed and randomized checks of alarm_controller against a seconds-based reference model.
module tb_alarm_controller;

    localparam int NUM         = 4;
    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int DAY         = 86400;
    localparam int Quiet       = 0;
    localparam int Ringing     = 1;
    localparam int Snoozed     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_1hz;
    logic [19:0] cur_time;
    logic        set_time;
    logic        set_alarm;
    logic [1:0]  alarm_id;
    logic [19:0] stime_alarm;
    logic        sam_pm;
    logic        alarm_arm;
    logic        mode12h;
    logic        button1;
    logic        button2;
    logic        ringing;
    logic        snoozing;
    logic [1:0]  active_id;
    logic        buzzer;
    logic [3:0]  slot_armed;

    always #5 clk = ~clk;

    alarm_controller #(
        .NUM_ALARMS (NUM),
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .cur_time   (cur_time),
        .set_time   (set_time),
        .set_alarm  (set_alarm),
        .alarm_id   (alarm_id),
        .stime_alarm(stime_alarm),
        .sam_pm     (sam_pm),
        .alarm_arm  (alarm_arm),
        .mode12h    (mode12h),
        .button1    (button1),
        .button2    (button2),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .active_id  (active_id),
        .buzzer     (buzzer),
        .slot_armed (slot_armed)
    );

    int n_vec;
    int n_err;

    // Reference model: alarm times kept as seconds since midnight.
    int m_slot [NUM];
    bit m_arm  [NUM];
    bit m_pend [NUM];
    int m_mode;
    int m_who;
    int m_secs;
    bit m_sa, m_b1, m_b2;
    int cur_sec;

    function automatic logic [19:0] pack(int ht, int hu, int mt, int mu, int st, int su);
        return {2'(ht), 4'(hu), 3'(mt), 4'(mu), 3'(st), 4'(su)};
    endfunction

    function automatic logic [19:0] sec_to_bcd(int s);
        return pack(s / 36000, (s / 3600) % 10, (s / 600) % 6, (s / 60) % 10,
                    (s % 60) / 10, s % 10);
    endfunction

    // Seconds since midnight of a written alarm, or -1 when the write must be ignored.
    function automatic int decode_alarm(logic [19:0] t, bit m12, bit pm);
        int ht = int'(t[19:18]);
        int hu = int'(t[17:14]);
        int mt = int'(t[13:11]);
        int mu = int'(t[10:7]);
        int st = int'(t[6:4]);
        int su = int'(t[3:0]);
        int h;
        if (hu > 9 || mu > 9 || su > 9 || mt > 5 || st > 5) return -1;
        h = ht * 10 + hu;
        if (m12) begin
            if (h < 1 || h > 12) return -1;
            h = (h % 12) + (pm ? 12 : 0);
        end else if (h > 23) begin
            return -1;
        end
        return h * 3600 + (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_slot[i] = 0;
            m_arm[i]  = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_mode = Quiet;
        m_who  = 0;
        m_secs = 0;
        m_sa   = 1'b0;
        m_b1   = 1'b0;
        m_b2   = 1'b0;
    endtask

    task automatic model_clock();
        bit e_sa, e_b1, e_b2;
        bit hit [NUM];
        int pick;
        int t;
        e_sa = set_alarm && !m_sa;
        e_b1 = button1 && !m_b1;
        e_b2 = button2 && !m_b2;
        m_sa = set_alarm;
        m_b1 = button1;
        m_b2 = button2;
        for (int i = 0; i < NUM; i++) begin
            hit[i] = tick_1hz && !set_time && m_arm[i] && (m_slot[i] == cur_sec);
        end
        if (m_mode == Quiet) begin
            pick = -1;
            for (int i = 0; i < NUM; i++) begin
                if (m_pend[i] && pick < 0) pick = i;
            end
            if (pick >= 0) begin
                m_pend[pick] = 1'b0;
                m_mode       = Ringing;
                m_who        = pick;
                m_secs       = 0;
            end
        end else if (m_mode == Ringing) begin
            if (e_b2 || (tick_1hz && m_secs + 1 == RING_SECS)) begin
                m_mode = Quiet;
            end else if (e_b1) begin
                m_mode = Snoozed;
                m_secs = 0;
            end else if (tick_1hz) begin
                m_secs++;
            end
        end else begin
            if (e_b2) begin
                m_mode = Quiet;
            end else if (tick_1hz && m_secs + 1 == SNOOZE_SECS) begin
                m_mode = Ringing;
                m_secs = 0;
            end else if (tick_1hz) begin
                m_secs++;
            end
        end
        for (int i = 0; i < NUM; i++) begin
            if (hit[i]) m_pend[i] = 1'b1;
        end
        if (e_sa) begin
            t = decode_alarm(stime_alarm, mode12h, sam_pm);
            if (t >= 0) begin
                m_slot[alarm_id] = t;
                m_arm[alarm_id]  = alarm_arm;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [3:0] arm_v;
        bit         buz;
        for (int i = 0; i < NUM; i++) arm_v[i] = m_arm[i];
`ifdef ALARM_BEEP_EN
        buz = (m_mode == Ringing) && (m_secs % 2 == 0);
`else
        buz = (m_mode == Ringing);
`endif
        check({where, ".ringing"}, 32'(ringing), 32'(m_mode == Ringing));
        check({where, ".snoozing"}, 32'(snoozing), 32'(m_mode == Snoozed));
        check({where, ".active_id"}, 32'(active_id), (m_mode == Quiet) ? 32'd0 : 32'(m_who));
        check({where, ".buzzer"}, 32'(buzzer), 32'(buz));
        check({where, ".slot_armed"}, 32'(slot_armed), 32'(arm_v));
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_clock();
        #1;
        check_all(where);
    endtask

    task automatic drive_time(input int s);
        cur_sec  = s;
        cur_time = sec_to_bcd(s);
    endtask

    task automatic tick_only(input string where);
        drive_time((cur_sec + 1) % DAY);
        tick_1hz = 1'b1;
        step(where);
        tick_1hz = 1'b0;
    endtask

    task automatic do_tick(input string where);
        tick_only(where);
        step(where);
    endtask

    task automatic write_alarm(input int id, input logic [19:0] t, input bit m12, input bit pm,
                               input bit arm);
        alarm_id    = 2'(id);
        stime_alarm = t;
        mode12h     = m12;
        sam_pm      = pm;
        alarm_arm   = arm;
        set_alarm   = 1'b1;
        step("write");
        set_alarm = 1'b0;
        step("write_idle");
    endtask

    task automatic press(input int which, input string where);
        if (which == 1) button1 = 1'b1;
        else button2 = 1'b1;
        step(where);
        button1 = 1'b0;
        button2 = 1'b0;
    endtask

    function automatic int dig(int lim, int max);
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, max))
                                           : int'($urandom_range(0, lim));
    endfunction

    initial begin
        logic [3:0] beep_exp;
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        tick_1hz    = 1'b0;
        set_time    = 1'b0;
        set_alarm   = 1'b0;
        alarm_id    = 2'd0;
        stime_alarm = '0;
        sam_pm      = 1'b0;
        alarm_arm   = 1'b0;
        mode12h     = 1'b0;
        button1     = 1'b0;
        button2     = 1'b0;
        drive_time(0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        step("idle");

        // 07:30 PM in 12h mode rings at 19:30:00, two cycles after the tick.
        write_alarm(0, pack(0, 7, 3, 0, 0, 0), 1'b1, 1'b1, 1'b1);
        check("armed_id0", 32'(slot_armed), 32'h1);
        drive_time(19 * 3600 + 30 * 60 - 1);
        tick_only("match");
        check("ring_after_1clk", 32'(ringing), 32'h0);
        step("match");
        check("ring_after_2clk", 32'(ringing), 32'h1);
        check("active_id0", 32'(active_id), 32'h0);

        repeat (RING_SECS - 1) do_tick("ringing");
        check("ring_tick59", 32'(ringing), 32'h1);
        tick_only("auto_dismiss");
        check("ring_tick60", 32'(ringing), 32'h0);
        step("idle_after_auto");

        // Snooze, re-ring after SNOOZE_SECS, then dismiss.
        drive_time(19 * 3600 + 30 * 60 - 1);
        do_tick("rematch");
        press(1, "snooze");
        check("snoozing", 32'(snoozing), 32'h1);
        check("snooze_ring_off", 32'(ringing), 32'h0);
        repeat (SNOOZE_SECS - 1) do_tick("snoozed");
        check("snooze_tick299", 32'(snoozing), 32'h1);
        tick_only("snooze_end");
        check("rering", 32'(ringing), 32'h1);
        check("rering_id", 32'(active_id), 32'h0);
        step("rering");
        press(2, "dismiss");
        check("dismiss_ring", 32'(ringing), 32'h0);
        check("dismiss_snz", 32'(snoozing), 32'h0);
        check("dismiss_id", 32'(active_id), 32'h0);
        check("dismiss_buz", 32'(buzzer), 32'h0);
        step("idle");

        // Two slots on the same time: lower index first, the other right after dismiss.
        write_alarm(1, pack(0, 6, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        write_alarm(3, pack(0, 6, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        check("armed_1011", 32'(slot_armed), 32'hb);
        drive_time(6 * 3600 - 1);
        do_tick("dual");
        check("dual_first", 32'(active_id), 32'h1);
        press(2, "dual_dismiss");
        check("dual_gap", 32'(ringing), 32'h0);
        step("dual_next");
        check("dual_second", 32'(active_id), 32'h3);
        check("dual_second_ring", 32'(ringing), 32'h1);
`ifdef ALARM_BEEP_EN
        beep_exp = 4'b0101;
`else
        beep_exp = 4'b1111;
`endif
        for (int k = 0; k < 4; k++) begin
            check("beep", 32'(buzzer), 32'(beep_exp[k]));
            do_tick("beep");
        end
        press(2, "dual_dismiss2");
        step("idle");

        // Invalid writes leave slots and arm flags alone; set_time blocks matching.
        write_alarm(1, pack(1, 2, 7, 5, 0, 0), 1'b0, 1'b0, 1'b0);
        check("bad24_armed", 32'(slot_armed), 32'hb);
        write_alarm(3, pack(0, 0, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        check("bad12_armed", 32'(slot_armed), 32'hb);
        set_time = 1'b1;
        drive_time(6 * 3600 - 1);
        do_tick("set_time");
        step("set_time");
        check("set_time_quiet", 32'(ringing), 32'h0);
        set_time = 1'b0;
        drive_time(6 * 3600 - 1);
        do_tick("slot_kept");
        check("slot1_kept", 32'(active_id), 32'h1);
        press(2, "kept_dismiss");
        step("kept_next");
        check("slot3_kept", 32'(active_id), 32'h3);

        // Asynchronous reset in the middle of a ring.
        #2;
        rst = 1'b0;
        #1;
        check("rst_ringing", 32'(ringing), 32'h0);
        check("rst_buzzer", 32'(buzzer), 32'h0);
        check("rst_armed", 32'(slot_armed), 32'h0);
        check("rst_snoozing", 32'(snoozing), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all("post_reset");

        // Random traffic: writes (some invalid), ticks aimed at stored times, buttons.
        for (int c = 0; c < 6000; c++) begin
            tick_1hz = ($urandom_range(0, 99) < 40);
            if (tick_1hz) begin
                if ($urandom_range(0, 9) < 5) drive_time((cur_sec + 1) % DAY);
                else if ($urandom_range(0, 9) < 6) drive_time(m_slot[$urandom_range(0, NUM - 1)]);
                else drive_time(int'($urandom_range(0, DAY - 1)));
            end
            set_time = ($urandom_range(0, 99) < 5);
            if (set_alarm) begin
                set_alarm = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 99) < 4) begin
                alarm_id    = 2'($urandom_range(0, 3));
                mode12h     = 1'($urandom_range(0, 1));
                sam_pm      = 1'($urandom_range(0, 1));
                alarm_arm   = ($urandom_range(0, 3) != 0);
                stime_alarm = pack(dig(2, 3), dig(9, 15), dig(5, 7), dig(9, 15), dig(5, 7),
                                   dig(9, 15));
                set_alarm   = 1'b1;
            end
            button1 = button1 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) < 3);
            button2 = button2 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) < 2);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
